uart_rx_fifo_ctrl: RTL and testbench
====================================

# uart_rx_fifo_ctrl

Receive-side buffer controller that sequences characters from the UART receiver datapath into a DEPTH-entry receive FIFO. It tags each character with its error flags, tracks line-status bits (DR, OE, PE, FE, BI, RX FIFO error) and generates the receive-data and character-timeout interrupt requests. It sits between the receiver top (rsr_data, parity_error, frame_error, error_check strobe) and the APB register block (RBR/LSR reads, FCR configuration).

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 4
- pclk  in  1  APB clock; single clock domain
- presetn  in  1  asynchronous, active-low reset
- utrrst  in  1  synchronous receiver/FIFO reset (FCR RX reset); clears FIFO, counters and status
- fifo_en  in  1  1 = FIFO mode (DEPTH entries); 0 = holding-register mode (1 entry)
- trig_lvl  in  2  RX trigger: 00=1, 01=DEPTH/4, 10=DEPTH/2, 11=DEPTH-2
- rx_valid  in  1  one-cycle pulse: character complete (receiver error_check)
- rx_data  in  8  received character
- rx_pe, rx_fe, rx_bi  in  1 each  parity error, framing error, break for rx_data
- rd_en  in  1  one-cycle RBR read pulse (pop)
- lsr_rd  in  1  one-cycle LSR read pulse
- char_tick  in  1  one pulse per character time from baud logic (used only with UART_RX_TIMEOUT_EN)
- rd_data  out  8  head character; 0x00 when empty
- count  out  $clog2(DEPTH)+1  entries held
- dr, oe, pe, fe, bi, rx_fifo_err  out  1 each  LSR bits
- rx_data_irq, rx_timeout_irq  out  1 each  interrupt requests

## Operation
- Entry = {bi, fe, pe, data[7:0]}; write pointer, read pointer and count registered.
- Effective capacity CAP = fifo_en ? DEPTH : 1.
- Push: rx_valid && count < CAP → store entry, count+1.
- Overrun: rx_valid && count == CAP && !rd_en → character discarded, FIFO unchanged, oe set.
- Pop: rd_en && count > 0 → advance read pointer, count−1. rd_en on empty is ignored.
- Simultaneous push and pop:
  - count == CAP: pop then push; no overrun; count unchanged.
  - count == 0: push only.
  - otherwise: both occur; count unchanged.
- Pointers wrap modulo DEPTH. In holding-register mode the pointers still advance; only the count is bounded.
- rd_data, pe, fe, bi reflect the head entry combinationally; all are 0 when empty.
- dr = (count != 0).
- oe is sticky; cleared by lsr_rd. If lsr_rd and a new overrun occur in the same cycle, oe = 1.
- Error counter err_cnt (same width as count):
  - +1 on push of an entry with any of pe/fe/bi set; −1 on pop of such an entry; both in the same cycle → unchanged.
  - rx_fifo_err = fifo_en && err_cnt != 0.
- rx_data_irq = fifo_en ? (count ≥ trigger value) : dr.
- fifo_en change (either edge, detected against a registered copy) → FIFO, count, err_cnt and timeout counter cleared on the next cycle; oe preserved.
- utrrst → same clear as a fifo_en change, plus oe cleared; utrrst has priority over push and pop in the same cycle.

## Timing
- Reset value of every registered output and internal state is 0: count, oe, err_cnt, pointers, timeout counter.
- Push is visible on count, dr and rd_data the cycle after rx_valid.
- Pop is visible the cycle after rd_en; rd_data presents the new head in that cycle.
- presetn assertion mid-character discards all buffered data immediately.
- rx_data_irq and rx_fifo_err are combinational from registers: no added latency beyond the push/pop update.

## Configuration
- UART_RX_TIMEOUT_EN defined:
  - 3-bit timeout counter increments on char_tick while count != 0 and fifo_en = 1, saturating at 4.
  - Counter clears on push, pop, empty, fifo_en change or utrrst.
  - rx_timeout_irq = (counter == 4).
- UART_RX_TIMEOUT_EN undefined: no counter, rx_timeout_irq tied 0, char_tick ignored.

## Structure
- Package uart_rx_pkg holds:
  - rx_entry_t packed struct {bi, fe, pe, data}
  - trig_lvl_e enum
  - RX_TIMEOUT_CHARS = 4
  - function trig_value(trig_lvl, DEPTH)
- Sub-module uart_rx_fifo_mem: storage array, write/read pointers and head readout.
- Count, flags, interrupts and timeout logic remain in uart_rx_fifo_ctrl.

## Test plan
- fifo_en=1, push 0x41,0x42,0x43, pop three times → rd_data 0x41,0x42,0x43 in order; count 3→0; dr falls after the third pop.
- DEPTH=16, fill 16, push 0x55 → oe=1, count=16, 0x55 never read; lsr_rd → oe=0. Repeat with rd_en coincident with the 17th push → oe stays 0, 0x55 last out.
- Push 0x10 (pe=1) then 0x20 clean → pe=1 and rx_fifo_err=1 while 0x10 at head; after pop pe=0, rx_fifo_err=0.
- trig_lvl=10, push 7 → rx_data_irq=0; 8th push → 1; one pop → 0. fifo_en=0: single push → irq=1, second push without read → oe=1.
- UART_RX_TIMEOUT_EN, 2 entries, 4 char_ticks with no access → rx_timeout_irq=1; rd_en → 0 next cycle; 3 ticks → stays 0.
- 5 entries held, pulse utrrst with concurrent rx_valid → count=0, dr=0, oe=0, rx_fifo_err=0 next cycle; toggling fifo_en clears FIFO but keeps oe.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive FIFO controller.
package uart_rx_pkg;

    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        TrigOne      = 2'b00,
        TrigQuarter  = 2'b01,
        TrigHalf     = 2'b10,
        TrigNearFull = 2'b11
    } trig_lvl_e;

    localparam int unsigned RX_TIMEOUT_CHARS = 4;

    function automatic int unsigned trig_value(trig_lvl_e lvl, int unsigned depth);
        int unsigned val;
        case (lvl)
            TrigOne:     val = 1;
            TrigQuarter: val = depth / 4;
            TrigHalf:    val = depth / 2;
            default:     val = depth - 2;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: entry array, wrapping write/read pointers and head readout.
module uart_rx_fifo_mem
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic      pclk,
    input  logic      presetn,
    input  logic      clr,
    input  logic      push,
    input  logic      pop,
    input  rx_entry_t wr_entry,
    output rx_entry_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    rx_entry_t       mem [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the controller masks the head whenever count is zero.
    always_ff @(posedge pclk) begin
        if (push && !clr) mem[wptr_q] <= wr_entry;
    end

    assign head = mem[rptr_q];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO controller: count, line-status flags and RX interrupts.
// Optional character-timeout interrupt enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic                     utrrst,
    input  logic                     fifo_en,
    input  logic [1:0]               trig_lvl,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     rx_pe,
    input  logic                     rx_fe,
    input  logic                     rx_bi,
    input  logic                     rd_en,
    input  logic                     lsr_rd,
    input  logic                     char_tick,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dr,
    output logic                     oe,
    output logic                     pe,
    output logic                     fe,
    output logic                     bi,
    output logic                     rx_fifo_err,
    output logic                     rx_data_irq,
    output logic                     rx_timeout_irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          oe_q, oe_d;
    logic          fifo_en_q;

    logic          clr, push, pop, overrun, inc, dec;
    logic [CW-1:0] cap, trig;
    rx_entry_t     wr_entry, head_raw, head;

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .pclk     (pclk),
        .presetn  (presetn),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head_raw)
    );

    always_comb begin
        clr      = utrrst || (fifo_en != fifo_en_q);
        cap      = fifo_en ? CW'(DEPTH) : CW'(1);
        trig     = CW'(trig_value(trig_lvl_e'(trig_lvl), DEPTH));
        pop      = rd_en && (count_q != '0);
        // A read in the same cycle frees the slot, so a full FIFO still accepts the push.
        push     = rx_valid && ((count_q < cap) || pop);
        overrun  = rx_valid && (count_q >= cap) && !rd_en;
        wr_entry = '{bi: rx_bi, fe: rx_fe, pe: rx_pe, data: rx_data};
        head     = (count_q != '0) ? head_raw : '0;
        inc      = push && (rx_pe || rx_fe || rx_bi);
        dec      = pop && (head_raw.pe || head_raw.fe || head_raw.bi);

        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (inc && !dec)       err_cnt_d = err_cnt_q + CW'(1);
            else if (dec && !inc)  err_cnt_d = err_cnt_q - CW'(1);
        end

        oe_d = oe_q;
        if (utrrst)       oe_d = 1'b0;
        else if (overrun) oe_d = 1'b1;
        else if (lsr_rd)  oe_d = 1'b0;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count_q   <= '0;
            err_cnt_q <= '0;
            oe_q      <= 1'b0;
            fifo_en_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            oe_q      <= oe_d;
            fifo_en_q <= fifo_en;
        end
    end

    always_comb begin
        rd_data     = head.data;
        pe          = head.pe;
        fe          = head.fe;
        bi          = head.bi;
        count       = count_q;
        dr          = (count_q != '0);
        oe          = oe_q;
        rx_fifo_err = fifo_en && (err_cnt_q != '0);
        rx_data_irq = fifo_en ? (count_q >= trig) : dr;
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [2:0] to_q, to_d;

    always_comb begin
        to_d = to_q;
        if (clr || push || pop || (count_q == '0)) begin
            to_d = '0;
        end else if (char_tick && fifo_en && (to_q != 3'(RX_TIMEOUT_CHARS))) begin
            to_d = to_q + 3'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) to_q <= '0;
        else          to_q <= to_d;
    end

    assign rx_timeout_irq = (to_q == 3'(RX_TIMEOUT_CHARS));
`else
    logic unused_char_tick;
    assign unused_char_tick = char_tick;
    assign rx_timeout_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Randomized self-checking bench for uart_rx_fifo_ctrl against a queue-based model.
module tb_uart_rx_fifo_ctrl;

    localparam int DEPTH = 16;

    logic       pclk = 1'b0;
    logic       presetn, utrrst, fifo_en, rx_valid, rx_pe, rx_fe, rx_bi;
    logic       rd_en, lsr_rd, char_tick;
    logic [1:0] trig_lvl;
    logic [7:0] rx_data, rd_data;
    logic [4:0] count;
    logic       dr, oe, pe, fe, bi, rx_fifo_err, rx_data_irq, rx_timeout_irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [10:0] q[$];
    bit        m_oe;
    bit        m_prev_fen;
    int        m_to;

    uart_rx_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .utrrst         (utrrst),
        .fifo_en        (fifo_en),
        .trig_lvl       (trig_lvl),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_pe          (rx_pe),
        .rx_fe          (rx_fe),
        .rx_bi          (rx_bi),
        .rd_en          (rd_en),
        .lsr_rd         (lsr_rd),
        .char_tick      (char_tick),
        .rd_data        (rd_data),
        .count          (count),
        .dr             (dr),
        .oe             (oe),
        .pe             (pe),
        .fe             (fe),
        .bi             (bi),
        .rx_fifo_err    (rx_fifo_err),
        .rx_data_irq    (rx_data_irq),
        .rx_timeout_irq (rx_timeout_irq)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int trig_of(input logic [1:0] t);
        case (t)
            2'd0:    return 1;
            2'd1:    return DEPTH / 4;
            2'd2:    return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_oe       = 0;
        m_prev_fen = 0;
        m_to       = 0;
    endtask

    // Applies the buffer rules to the inputs seen at the clock edge.
    task automatic model_update();
        int  cap;
        int  size;
        bit  clear, do_pop, do_push, ovr;
        cap     = fifo_en ? DEPTH : 1;
        size    = q.size();
        clear   = utrrst || (fifo_en != m_prev_fen);
        do_pop  = rd_en && size > 0;
        do_push = rx_valid && (size < cap || do_pop);
        ovr     = rx_valid && size >= cap && !rd_en;
        if (utrrst)      m_oe = 0;
        else if (ovr)    m_oe = 1;
        else if (lsr_rd) m_oe = 0;
        if (clear || do_push || do_pop || size == 0) m_to = 0;
        else if (char_tick && fifo_en && m_to < 4)   m_to++;
        if (clear) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({rx_bi, rx_fe, rx_pe, rx_data});
        end
        m_prev_fen = fifo_en;
    endtask

    task automatic compare_all();
        bit [10:0] h;
        bit        any_err;
        h = (q.size() != 0) ? q[0] : 11'd0;
        any_err = 0;
        foreach (q[i]) if (q[i][10:8] != 3'b000) any_err = 1;
        check("count", count, q.size());
        check("dr", dr, q.size() != 0);
        check("rd_data", rd_data, h[7:0]);
        check("pe", pe, h[8]);
        check("fe", fe, h[9]);
        check("bi", bi, h[10]);
        check("oe", oe, m_oe);
        check("rx_fifo_err", rx_fifo_err, fifo_en && any_err);
        check("rx_data_irq", rx_data_irq,
              fifo_en ? (q.size() >= trig_of(trig_lvl)) : (q.size() != 0));
`ifdef UART_RX_TIMEOUT_EN
        check("rx_timeout_irq", rx_timeout_irq, m_to == 4);
`else
        check("rx_timeout_irq", rx_timeout_irq, 0);
`endif
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] err,
                        input logic rd, input logic lr, input logic tk, input logic ur);
        rx_valid  = v;
        rx_data   = d;
        {rx_bi, rx_fe, rx_pe} = err;
        rd_en     = rd;
        lsr_rd    = lr;
        char_tick = tk;
        utrrst    = ur;
        @(posedge pclk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] err = 3'b000);
        step(1'b1, d, err, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic tk = 1'b0);
        step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, tk, 1'b0);
    endtask

    task automatic fill_full();
        for (int i = 0; i < DEPTH; i++) push(8'(i));
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) pop();
    endtask

    initial begin
        presetn = 1'b0; utrrst = 1'b0; fifo_en = 1'b1; trig_lvl = 2'd0;
        rx_valid = 1'b0; rx_data = 8'h00; rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0;
        rd_en = 1'b0; lsr_rd = 1'b0; char_tick = 1'b0;
        model_reset();
        #12;
        check("reset_count", count, 0);
        check("reset_dr", dr, 0);
        check("reset_oe", oe, 0);
        @(negedge pclk);
        presetn = 1'b1;
        idle(); idle();

        // In-order delivery
        push(8'h41); push(8'h42); push(8'h43);
        check("order_head0", rd_data, 8'h41);
        pop();
        check("order_head1", rd_data, 8'h42);
        pop(); pop();
        check("order_dr_low", dr, 0);

        // Overrun and coincident-read full push
        fill_full();
        push(8'h55);
        check("ovr_oe", oe, 1);
        check("ovr_count", count, 16);
        step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovr_lsr_clear", oe, 0);
        drain();
        fill_full();
        step(1'b1, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("coinc_no_oe", oe, 0);
        for (int i = 0; i < DEPTH - 1; i++) pop();
        check("coinc_last55", rd_data, 8'h55);
        pop();

        // Error tagging
        push(8'h10, 3'b001); push(8'h20);
        check("err_pe", pe, 1);
        check("err_fifo", rx_fifo_err, 1);
        pop();
        check("err_pe_clear", pe, 0);
        check("err_fifo_clear", rx_fifo_err, 0);
        pop();

        // Trigger level
        trig_lvl = 2'd2;
        for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
        check("trig_below", rx_data_irq, 0);
        push(8'h67);
        check("trig_at", rx_data_irq, 1);
        pop();
        check("trig_after_pop", rx_data_irq, 0);
        drain();

        // Holding-register mode
        fifo_en = 1'b0;
        idle();
        push(8'h71);
        check("hold_irq", rx_data_irq, 1);
        push(8'h72);
        check("hold_oe", oe, 1);
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        fifo_en = 1'b1;
        idle();

        // Character timeout
        push(8'h81); push(8'h82);
        for (int i = 0; i < 4; i++) idle(1'b1);
        pop();
        for (int i = 0; i < 3; i++) idle(1'b1);
        drain();

        // utrrst with concurrent push, and fifo_en toggle keeps oe
        fill_full();
        push(8'h99);
        for (int i = 0; i < DEPTH - 5; i++) pop();
        check("ur_pre_count", count, 5);
        step(1'b1, 8'hA5, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ur_count", count, 0);
        check("ur_oe", oe, 0);
        fill_full();
        push(8'h99);
        fifo_en = 1'b0;
        idle();
        check("fen_toggle_count", count, 0);
        check("fen_toggle_oe", oe, 1);
        fifo_en = 1'b1;
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] e;
            if ($urandom_range(0, 49) == 0) trig_lvl = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                fifo_en = ~fifo_en;
                idle();
            end
            e = 3'b000;
            if ($urandom_range(0, 9) == 0) e = 3'($urandom_range(1, 7));
            step($urandom_range(0, 9) < 4, 8'($urandom), e,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 299) == 0);
        end

        // Asynchronous reset mid-stream
        fill_full();
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        model_reset();
        check("async_rst_count", count, 0);
        check("async_rst_dr", dr, 0);
        #3;
        presetn = 1'b1;
        idle(); idle();
        push(8'h3C);
        check("post_rst_head", rd_data, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
